jump_target_gen: RTL and testbench

- Parametrised, pipelined successor to the combinational jump-field shifter.
- Computes the next-PC target for pseudo-direct jumps (J/JAL), PC-relative branches and register jumps (JR) from fields delivered by decode.
- Sits between decode and the PC-select mux; two register stages with valid/ready handshaking and a pipeline flush.
- Flags misaligned register targets and reserved modes.

---
 rtl/jump_target_gen.sv | 143 ++++++++++++++
 tb/tb_jump_target_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_target_gen.sv
// Two-stage jump/branch/register target generator between decode and PC select.
// S1 aligns the jump field, S2 merges it with the PC and raises the fault flags.
module jump_target_gen #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 26,
    parameter int OFF_W  = 16,
    parameter int SHIFT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [IDX_W-1:0]  index,
    input  logic [OFF_W-1:0]  offset,
    input  logic [ADDR_W-1:0] rs_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] target,
    output logic              misaligned,
    output logic              illegal
);

    localparam logic [1:0] MODE_J  = 2'b00;
    localparam logic [1:0] MODE_BR = 2'b01;
    localparam logic [1:0] MODE_JR = 2'b10;

    localparam int JW = IDX_W + SHIFT;

    // Bits of the target that come from the jump field rather than the PC.
    localparam logic [ADDR_W-1:0] JMASK =
        (JW >= ADDR_W) ? {ADDR_W{1'b1}}
                       : ((ADDR_W'(1) << JW) - ADDR_W'(1));

    // Low bits that must be zero in an aligned register target.
    localparam logic [ADDR_W-1:0] LOW_MASK =
        (ADDR_W'(1) << SHIFT) - ADDR_W'(1);

    logic              s1_valid_q;
    logic [1:0]        s1_mode_q;
    logic [ADDR_W-1:0] s1_shift_q;
    logic [ADDR_W-1:0] s1_pc_q;

    logic              s2_valid_q;
    logic [ADDR_W-1:0] s2_tgt_q;
    logic              s2_mis_q;
    logic              s2_ill_q;

    logic              s2_adv;
    logic              s1_adv;
    logic              in_fire;

    logic [ADDR_W-1:0] idx_ext;
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] s1_shift_d;
    logic [ADDR_W-1:0] s2_tgt_d;
    logic              s2_mis_d;
    logic              s2_ill_d;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv && !flush;
    assign in_fire  = in_valid && in_ready;

    assign idx_ext = ADDR_W'(index);
    assign off_ext = ADDR_W'($signed(offset));

    always_comb begin
        s1_shift_d = '0;
        case (mode)
            MODE_J:  s1_shift_d = idx_ext << SHIFT;
            MODE_BR: s1_shift_d = off_ext << SHIFT;
            MODE_JR: s1_shift_d = rs_val;
            default: s1_shift_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= '0;
            s1_shift_q <= '0;
            s1_pc_q    <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_fire) begin
                s1_mode_q  <= mode;
                s1_shift_q <= s1_shift_d;
                s1_pc_q    <= pc_plus4;
            end
        end
    end

    always_comb begin
        s2_tgt_d = s1_pc_q;
        s2_mis_d = 1'b0;
        s2_ill_d = 1'b0;
        case (s1_mode_q)
            MODE_J: begin
                s2_tgt_d = (s1_pc_q & ~JMASK) | (s1_shift_q & JMASK);
            end
            MODE_BR: begin
                s2_tgt_d = s1_pc_q + s1_shift_q;
            end
            MODE_JR: begin
                s2_tgt_d = s1_shift_q;
                s2_mis_d = |(s1_shift_q & LOW_MASK);
            end
            default: begin
                s2_tgt_d = s1_pc_q;
                s2_ill_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_tgt_q   <= '0;
            s2_mis_q   <= 1'b0;
            s2_ill_q   <= 1'b0;
        end else if (flush) begin
            s2_valid_q <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_tgt_q <= s2_tgt_d;
                s2_mis_q <= s2_mis_d;
                s2_ill_q <= s2_ill_d;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign target     = s2_tgt_q;
    assign misaligned = s2_mis_q;
    assign illegal    = s2_ill_q;

endmodule

// File: tb/tb_jump_target_gen.sv
// Directed bench for jump_target_gen: default build plus a SHIFT=0 build.
module tb_jump_target_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic [31:0] pc_plus4;
    logic [25:0] index;
    logic [15:0] offset;
    logic [31:0] rs_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] target;
    logic        misaligned;
    logic        illegal;

    logic        b_flush;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [1:0]  b_mode;
    logic [31:0] b_pc;
    logic [29:0] b_index;
    logic [31:0] b_offset;
    logic [31:0] b_rs;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [31:0] b_target;
    logic        b_mis;
    logic        b_ill;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jump_target_gen dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .pc_plus4(pc_plus4), .index(index),
        .offset(offset), .rs_val(rs_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .target(target), .misaligned(misaligned), .illegal(illegal)
    );

    jump_target_gen #(.ADDR_W(32), .IDX_W(30), .OFF_W(32), .SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mode(b_mode), .pc_plus4(b_pc), .index(b_index),
        .offset(b_offset), .rs_val(b_rs),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .target(b_target), .misaligned(b_mis), .illegal(b_ill)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mode = 2'b00; pc_plus4 = '0; index = '0; offset = '0; rs_val = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        b_mode = 2'b00; b_pc = '0; b_index = '0; b_offset = '0; b_rs = '0;
    endtask

    // Present one request for one cycle and wait until it sits in S2.
    task automatic send_one(input logic [1:0] m, input logic [31:0] pc,
                            input logic [25:0] idx, input logic [15:0] off,
                            input logic [31:0] rs);
        out_ready = 1'b1;
        mode = m; pc_plus4 = pc; index = idx; offset = off; rs_val = rs;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        idle();
        #1 reset = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || target !== 32'h0 ||
            misaligned !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b t=%h m=%b i=%b want 0 0 0 0",
                     out_valid, target, misaligned, illegal);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_jump;
        tick();
        out_ready = 1'b1;
        mode = 2'b00; pc_plus4 = 32'h0040_0010; index = 26'h100_0004;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL j_in_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL j_latency1: out_valid got %b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || target !== 32'h0400_0010 ||
            misaligned !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL j_target: got v=%b t=%h m=%b i=%b want 1 04000010 0 0",
                     out_valid, target, misaligned, illegal);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL j_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_branch;
        send_one(2'b01, 32'h0000_0004, '0, 16'hFFFE, '0);
        checks++;
        if (out_valid !== 1'b1 || target !== 32'hFFFF_FFFC || illegal !== 1'b0) begin
            errors++;
            $display("FAIL br_wrap: got v=%b t=%h i=%b want 1 fffffffc 0",
                     out_valid, target, illegal);
        end
        send_one(2'b01, 32'h1000_0000, '0, 16'h7FFF, '0);
        checks++;
        if (out_valid !== 1'b1 || target !== 32'h1001_FFFC) begin
            errors++;
            $display("FAIL br_maxpos: got v=%b t=%h want 1 1001fffc",
                     out_valid, target);
        end
    endtask

    task automatic test_jr_reserved;
        send_one(2'b10, 32'h0000_0100, '0, '0, 32'h0040_0006);
        checks++;
        if (target !== 32'h0040_0006 || misaligned !== 1'b1 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL jr_misaligned: got t=%h m=%b i=%b want 00400006 1 0",
                     target, misaligned, illegal);
        end
        send_one(2'b10, 32'h0000_0100, '0, '0, 32'h0040_0008);
        checks++;
        if (target !== 32'h0040_0008 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL jr_aligned: got t=%h m=%b want 00400008 0",
                     target, misaligned);
        end
        send_one(2'b11, 32'h0000_0100, 26'h3FF_FFFF, 16'h1234, 32'hDEAD_BEEF);
        checks++;
        if (target !== 32'h0000_0100 || illegal !== 1'b1 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reserved: got t=%h i=%b m=%b want 00000100 1 0",
                     target, illegal, misaligned);
        end
    endtask

    task automatic test_back_pressure;
        logic [31:0] got[4];
        int          cyc[4];
        int          ngot;
        int          nsent;
        logic        accept;
        tick();
        idle();
        out_ready = 1'b0;
        mode = 2'b01; pc_plus4 = 32'h0000_1000;
        offset = 16'd1; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept0: in_ready got %b want 1", in_ready);
        end
        tick();
        offset = 16'd2;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept1: in_ready got %b want 1", in_ready);
        end
        tick();
        offset = 16'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || target !== 32'h0000_1004) begin
                errors++;
                $display("FAIL bp_stall%0d: got rdy=%b v=%b t=%h want 0 1 00001004",
                         k, in_ready, out_valid, target);
            end
            tick();
        end
        out_ready = 1'b1;
        ngot = 0;
        nsent = 2;
        for (int c = 0; c < 10; c++) begin
            if (nsent < 4) begin
                in_valid = 1'b1;
                offset = 16'(nsent + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && ngot < 4) begin
                got[ngot] = target;
                cyc[ngot] = c;
                ngot++;
            end
            accept = in_valid && in_ready;
            tick();
            if (accept) nsent++;
        end
        checks++;
        if (ngot !== 4) begin
            errors++;
            $display("FAIL bp_count: got %0d results want 4", ngot);
        end
        for (int k = 0; k < ngot; k++) begin
            checks++;
            if (got[k] !== 32'h0000_1000 + 32'(4 * (k + 1)) || cyc[k] !== k) begin
                errors++;
                $display("FAIL bp_order%0d: got t=%h cyc=%0d want t=%h cyc=%0d",
                         k, got[k], cyc[k], 32'h0000_1000 + 32'(4 * (k + 1)), k);
            end
        end
    endtask

    task automatic test_flush;
        idle();
        out_ready = 1'b0;
        mode = 2'b10; rs_val = 32'h0000_2000; in_valid = 1'b1;
        tick();
        rs_val = 32'h0000_2004;
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre: out_valid got %b want 1", out_valid);
        end
        flush = 1'b1;
        rs_val = 32'h0000_2008;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: out_valid got %b want 0", out_valid);
        end
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_dropped: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset;
        idle();
        out_ready = 1'b0;
        mode = 2'b10; rs_val = 32'h0000_3000; in_valid = 1'b1;
        tick();
        rs_val = 32'h0000_3004;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || target !== 32'h0000_3000) begin
            errors++;
            $display("FAIL areset_pre: got v=%b t=%h want 1 00003000",
                     out_valid, target);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || target !== 32'h0) begin
            errors++;
            $display("FAIL areset_clear: got v=%b t=%h want 0 00000000",
                     out_valid, target);
        end
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_after: got rdy=%b v=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_shift0;
        idle();
        b_mode = 2'b00; b_pc = 32'hC000_0000; b_index = 30'h2345_6789;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        tick();
        checks++;
        if (b_out_valid !== 1'b1 || b_target !== 32'hE345_6789) begin
            errors++;
            $display("FAIL s0_j: got v=%b t=%h want 1 e3456789",
                     b_out_valid, b_target);
        end
        b_mode = 2'b01; b_pc = 32'h0000_0100; b_offset = 32'hFFFF_FFF0;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        tick();
        checks++;
        if (b_out_valid !== 1'b1 || b_target !== 32'h0000_00F0) begin
            errors++;
            $display("FAIL s0_br: got v=%b t=%h want 1 000000f0",
                     b_out_valid, b_target);
        end
        b_mode = 2'b10; b_rs = 32'h0040_0007;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        tick();
        checks++;
        if (b_target !== 32'h0040_0007 || b_mis !== 1'b0 || b_ill !== 1'b0) begin
            errors++;
            $display("FAIL s0_jr: got t=%h m=%b i=%b want 00400007 0 0",
                     b_target, b_mis, b_ill);
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_branch();
        test_jr_reserved();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_shift0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
